// File: rtl/oled_source_sched.sv
// Pixel-byte request scheduler between an OLED driver and two pattern sources.
// Each request goes to the current source; sources are switched only at frame boundaries.
module oled_source_sched #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned LAST_ROW = 7,
  parameter int unsigned LAST_COL = 95
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic [5:0] row_idx,
  input  logic [6:0] column_idx,
  output logic [7:0] data,
  output logic       ack,
  output logic       src0_read,
  output logic       src1_read,
  output logic [5:0] src_row_idx,
  output logic [6:0] src_column_idx,
  input  logic [7:0] src0_data,
  input  logic [7:0] src1_data,
  input  logic       src0_ack,
  input  logic       src1_ack,
  input  logic       sel_req,
  output logic       cur_src,
  output logic       frame_done,
  output logic       timeout_err,
  output logic       overrun_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          pending;

  logic       sel_ack_c;
  logic [7:0] sel_data_c;
  logic       last_c;

  assign sel_ack_c  = cur_src ? src1_ack : src0_ack;
  assign sel_data_c = cur_src ? src1_data : src0_data;
  assign last_c     = (src_row_idx == 6'(LAST_ROW)) && (src_column_idx == 7'(LAST_COL));

  // Request FSM; strobes default low and are raised only on the cycle they apply to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      pending        <= 1'b0;
      data           <= 8'h00;
      ack            <= 1'b0;
      src0_read      <= 1'b0;
      src1_read      <= 1'b0;
      src_row_idx    <= 6'd0;
      src_column_idx <= 7'd0;
      cur_src        <= 1'b0;
      frame_done     <= 1'b0;
      timeout_err    <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      src0_read  <= 1'b0;
      src1_read  <= 1'b0;
      ack        <= 1'b0;
      frame_done <= 1'b0;
      if (sel_req) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (read) begin
            src_row_idx    <= row_idx;
            src_column_idx <= column_idx;
            src0_read      <= ~cur_src;
            src1_read      <= cur_src;
            cnt            <= '0;
            state          <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (read) overrun_err <= 1'b1;
          if (sel_ack_c) begin
            data       <= sel_data_c;
            ack        <= 1'b1;
            frame_done <= last_c;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            data        <= 8'h00;
            timeout_err <= 1'b1;
            ack         <= 1'b1;
            frame_done  <= last_c;
            state       <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (read) overrun_err <= 1'b1;
          // Frame boundary: a sel_req landing on this very cycle also counts.
          if (last_c && (pending || sel_req)) begin
            cur_src <= ~cur_src;
            pending <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_source_sched.sv
// Directed bench for oled_source_sched with a one-cycle-latency source responder.
module tb_oled_source_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read = 1'b0;
  logic [5:0] row_idx = 6'd0;
  logic [6:0] column_idx = 7'd0;
  logic [7:0] data;
  logic       ack;
  logic       src0_read, src1_read;
  logic [5:0] src_row_idx;
  logic [6:0] src_column_idx;
  logic [7:0] src0_data, src1_data;
  logic       src0_ack, src1_ack;
  logic       sel_req = 1'b0;
  logic       cur_src, frame_done, timeout_err, overrun_err;

  logic       en0 = 1'b1, en1 = 1'b1;
  logic       auto0 = 1'b0, auto1 = 1'b0;
  logic       man0 = 1'b0, man1 = 1'b0;
  logic       pat_mode = 1'b0;
  logic [7:0] d0_const = 8'hAA;

  int n_vec = 0;
  int n_err = 0;

  oled_source_sched #(.TIMEOUT(16), .LAST_ROW(7), .LAST_COL(95)) dut (
    .clk(clk), .rst(rst), .read(read), .row_idx(row_idx), .column_idx(column_idx),
    .data(data), .ack(ack), .src0_read(src0_read), .src1_read(src1_read),
    .src_row_idx(src_row_idx), .src_column_idx(src_column_idx),
    .src0_data(src0_data), .src1_data(src1_data), .src0_ack(src0_ack), .src1_ack(src1_ack),
    .sel_req(sel_req), .cur_src(cur_src), .frame_done(frame_done),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat0(input logic [5:0] r, input logic [6:0] c);
    return 8'({2'b00, r} * 8'd13 + {1'b0, c});
  endfunction

  function automatic logic [7:0] pat1(input logic [5:0] r, input logic [6:0] c);
    return pat0(r, c) ^ 8'hFF;
  endfunction

  // Sources answer one cycle after seeing their read strobe.
  always @(posedge clk) begin
    auto0 <= src0_read & en0;
    auto1 <= src1_read & en1;
  end
  assign src0_ack  = auto0 | man0;
  assign src1_ack  = auto1 | man1;
  assign src0_data = pat_mode ? pat0(src_row_idx, src_column_idx) : d0_const;
  assign src1_data = pat1(src_row_idx, src_column_idx);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({data, ack, src0_read, src1_read, src_row_idx, src_column_idx,
                cur_src, frame_done, timeout_err, overrun_err});
  endfunction

  // One request; returns data, latency in cycles, which strobes fired, frame_done at ack.
  task automatic do_read(input logic [5:0] r, input logic [6:0] c, input bit sel_at_ack,
                         output logic [7:0] d, output int lat, output logic [1:0] srcs,
                         output logic fd);
    @(negedge clk);
    read = 1'b1; row_idx = r; column_idx = c;
    @(negedge clk);
    read = 1'b0;
    srcs = {src1_read, src0_read};
    lat = 1;
    while (!ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ack) chk("ack_seen", 32'd0, 32'd1);
    d  = data;
    fd = frame_done;
    if (sel_at_ack) sel_req = 1'b1;
    @(negedge clk);
    sel_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         lat, n_ack;
    logic [1:0] srcs;
    logic       fd;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;

    // Single read cycle by cycle
    @(negedge clk);
    read = 1'b1; row_idx = 6'd2; column_idx = 7'd9;
    @(negedge clk);
    read = 1'b0;
    chk("s_rd_c1", 32'({src1_read, src0_read, ack}), 32'b010);
    chk("s_idx", 32'({src_row_idx, src_column_idx}), 32'({6'd2, 7'd9}));
    @(negedge clk);
    chk("s_rd_c2", 32'({src1_read, src0_read, ack}), 32'b000);
    @(negedge clk);
    chk("s_ack", 32'({ack, data}), 32'({1'b1, 8'hAA}));
    @(negedge clk);
    chk("s_hold", 32'({ack, src1_read, data}), 32'({1'b0, 1'b0, 8'hAA}));

    // Overrun: second read one cycle after the first
    pat_mode = 1'b1;
    @(negedge clk);
    read = 1'b1; row_idx = 6'd4; column_idx = 7'd5;
    @(negedge clk);
    row_idx = 6'd1; column_idx = 7'd1;
    n_ack = 0;
    d = 8'h00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      read = 1'b0;
      if (ack) begin n_ack++; d = data; end
    end
    chk("ovr_nack", 32'(n_ack), 32'd1);
    chk("ovr_data", 32'(d), 32'(pat0(6'd4, 7'd5)));
    chk("ovr_idx", 32'({src_row_idx, src_column_idx}), 32'({6'd4, 7'd5}));
    chk("ovr_err", 32'({overrun_err, timeout_err}), 32'b10);

    // Full frame sweep with a mid-frame (repeated) sel_req
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 96; c++) begin
        if (r == 3 && c == 0) begin
          @(negedge clk); sel_req = 1'b1;
          @(negedge clk); sel_req = 1'b0;
          @(negedge clk); sel_req = 1'b1;
          @(negedge clk); sel_req = 1'b0;
        end
        if (r == 7 && c == 95) chk("sweep_mid_src", 32'(cur_src), 32'd0);
        do_read(6'(r), 7'(c), 1'b0, d, lat, srcs, fd);
        chk("sweep", 32'({fd, srcs, d}),
            32'({(r == 7 && c == 95), 2'b01, pat0(6'(r), 7'(c))}));
      end
    end
    chk("sweep_flip", 32'(cur_src), 32'd1);
    do_read(6'd0, 7'd0, 1'b0, d, lat, srcs, fd);
    chk("new_frame", 32'({srcs, d, fd}), 32'({2'b10, 8'hFF, 1'b0}));

    // Stalled source 1, with a stray source-0 ack that must be ignored
    en1 = 1'b0; man0 = 1'b1;
    do_read(6'd1, 7'd1, 1'b0, d, lat, srcs, fd);
    man0 = 1'b0; en1 = 1'b1;
    chk("to_lat", 32'(lat), 32'd17);
    chk("to_data", 32'(d), 32'h00);
    chk("to_err", 32'(timeout_err), 32'd1);
    do_read(6'd1, 7'd2, 1'b0, d, lat, srcs, fd);
    chk("to_sticky", 32'({timeout_err, d}), 32'({1'b1, pat1(6'd1, 7'd2)}));
    chk("norm_lat", 32'(lat), 32'd3);

    // sel_req coincident with the final-byte ack
    do_read(6'd7, 7'd95, 1'b1, d, lat, srcs, fd);
    chk("co_fd", 32'({fd, srcs, d}), 32'({1'b1, 2'b10, pat1(6'd7, 7'd95)}));
    chk("co_flip", 32'(cur_src), 32'd0);
    do_read(6'd7, 7'd95, 1'b0, d, lat, srcs, fd);
    chk("co_nopend", 32'({cur_src, fd, srcs}), 32'({1'b0, 1'b1, 2'b01}));

    // Reset in WAIT_ACK, then a late source ack
    en0 = 1'b0;
    @(negedge clk);
    read = 1'b1; row_idx = 6'd3; column_idx = 7'd3;
    @(negedge clk);
    read = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    man0 = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      man0 = 1'b0;
      if (ack) n_ack++;
    end
    chk("rst_noack", 32'(n_ack), 32'd0);
    chk("rst_outs", all_outs(), 32'd0);
    en0 = 1'b1;
    do_read(6'd2, 7'd9, 1'b0, d, lat, srcs, fd);
    chk("rst_after", 32'({srcs, d}), 32'({2'b01, pat0(6'd2, 7'd9)}));
    chk("rst_lat", 32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
